key_debounce_multi: RTL
=======================

Name: key_debounce_multi

Overview:
- Parametrised N-key debouncer and event generator for push-buttons on the board.
- Generalises the fixed 4-key debounce-plus-LED-toggle logic: independent per-key debounce, press/release/long-press pulses and per-key toggle state.
- Sits between raw KEY pins and the clock's mode/set logic.
- Simultaneous keys are all serviced; there is no priority.

Parameters:
- N_KEYS, 4, number of keys/channels.
- DB_CYCLES, 1_000_000, clocks input must differ from stable level before it is accepted (20 ms @ 50 MHz).
- LONG_CYCLES, 50_000_000, clocks of continuous debounced press before the long-press event (1 s).
- REPEAT_CYCLES, 10_000_000, auto-repeat period after a long press (200 ms); used only with the optional feature.
- TOGGLE_RST, all ones, reset value of the toggle outputs (1 = LED lit).

Ports:
- Clk_50MHz  in  1  system clock.
- Reset_N  in  1  asynchronous active-low reset.
- KEY_in  in  N_KEYS  raw key pins, 0 = pressed.
- KEY_level  out  N_KEYS  debounced level, 0 = pressed, 1 = released.
- KEY_press  out  N_KEYS  1-cycle pulse per key on debounced press.
- KEY_release  out  N_KEYS  1-cycle pulse per key on debounced release.
- KEY_long  out  N_KEYS  1-cycle pulse when the hold reaches LONG_CYCLES.
- KEY_repeat  out  N_KEYS  auto-repeat pulses; constant 0 when the feature is compiled out.
- LED_toggle  out  N_KEYS  per-key state, inverted on each KEY_press.

Behaviour:
- Reset (async assert, sync-free release):
  - KEY_level all 1.
  - KEY_press, KEY_release, KEY_long and KEY_repeat all 0.
  - LED_toggle = TOGGLE_RST.
  - All counters 0. Synchroniser flops preset to 1.
- Per key, independently:
  - 2-flop synchroniser on KEY_in[i].
  - Debounce counter clears whenever sync == stable, and increments while sync != stable.
  - When the counter == DB_CYCLES-1 and the mismatch is still present, stable <= sync and the counter clears.
  - A glitch shorter than DB_CYCLES leaves stable unchanged and restarts the count on the next mismatch.
- Latency:
  - KEY_level changes exactly 2 + DB_CYCLES clocks after a clean KEY_in edge.
  - KEY_press / KEY_release are asserted on the same edge that KEY_level changes, derived registered from the old/new stable value, for exactly 1 cycle.
- LED_toggle[i] inverts on the clock after KEY_press[i]. Multiple keys pressed on the same cycle each toggle their own bit.
- Hold counter:
  - Counts while stable == 0.
  - At LONG_CYCLES-1, KEY_long pulses once, then the counter saturates (no wrap).
  - Clears on release.
- Counter widths are $clog2(param) bits. Parameters must be >= 2; a parameter of 1 is illegal.
- Reset mid-operation: all state is discarded. A key held through reset release is seen as a new press after 2 + DB_CYCLES clocks.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - After KEY_long[i], a per-key repeat counter runs.
  - KEY_repeat[i] pulses every REPEAT_CYCLES clocks while the key stays pressed; the first pulse comes REPEAT_CYCLES after KEY_long.
  - Release stops it immediately with no trailing pulse.
  - Repeats do not toggle LED_toggle.
- Undefined: KEY_repeat tied 0, no repeat counter logic is synthesised, and REPEAT_CYCLES is ignored.

Decomposition:
- Package key_pkg:
  - Default constants CLK_HZ = 50_000_000 and KEY_PRESSED = 1'b0.
  - Helper localparams for ms-to-cycles conversion.
  - Typedef for the per-key event bundle (press/release/long/repeat).
- Sub-module key_channel: one key's synchroniser, debounce, hold/repeat counters and toggle bit.
- Top module instantiates N_KEYS copies via generate and concatenates the outputs.

Test Plan:
- Common settings: N_KEYS=4, DB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10.
- Reset only:
  - Stimulus: assert Reset_N=0 with KEY_in=4'hF, then release.
  - Expected: KEY_level=4'hF, LED_toggle=4'hF, all pulse outputs 0 for 100 clocks.
- Clean press:
  - Stimulus: KEY_in[1] 1->0.
  - Expected: KEY_level[1]=0 and KEY_press[1]=1 exactly 10 clocks later, for 1 cycle only.
  - Expected: LED_toggle changes 4'hF -> 4'hD the next cycle.
- Bounce and glitch:
  - Stimulus: 5-cycle low glitch on KEY_in[0], then 0/1 chatter every 3 cycles followed by a steady 0.
  - Expected: no event during the glitch or chatter.
  - Expected: exactly one KEY_press[0], 10 clocks after the last transition.
- Simultaneous keys:
  - Stimulus: KEY_in 4'hF -> 4'h0 on one edge.
  - Expected: KEY_press = 4'hF on a single cycle; LED_toggle 4'hF -> 4'h0.
  - Expected: release gives KEY_release = 4'hF.
- Long press and repeat:
  - Stimulus: hold key 2.
  - Expected: one KEY_long[2] pulse 40 clocks after KEY_press[2].
  - With KEY_AUTO_REPEAT_EN: KEY_repeat[2] every 10 clocks; no further pulse after release.
  - Without the macro: KEY_repeat stays 0.
- Reset mid-debounce:
  - Stimulus: KEY_in[3]=0, pulse Reset_N low at count 5, keep the key low.
  - Expected: KEY_press[3] 10 clocks after reset release; LED_toggle=4'hF before it.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the push-button debouncer (key_channel, key_debounce_multi).
package key_pkg;

    localparam int   CLK_HZ        = 50_000_000;
    localparam logic KEY_PRESSED   = 1'b0;
    localparam int   CYCLES_PER_MS = CLK_HZ / 1000;

    localparam int DB_MS     = 20;
    localparam int LONG_MS   = 1000;
    localparam int REPEAT_MS = 200;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

    // One-cycle event pulses produced by a single key channel.
    typedef struct packed {
        logic press;
        logic rel;
        logic hold_long;
        logic rpt;
    } key_event_t;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce, hold/long-press counter, optional auto-repeat
// (KEY_AUTO_REPEAT_EN) and the per-key toggle bit.
module key_channel
    import key_pkg::*;
#(
    parameter int   DB_CYCLES     = ms_to_cycles(DB_MS),
    parameter int   LONG_CYCLES   = ms_to_cycles(LONG_MS),
`ifdef KEY_AUTO_REPEAT_EN
    parameter int   REPEAT_CYCLES = ms_to_cycles(REPEAT_MS),
`endif
    parameter logic TOGGLE_RST    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_raw,
    output logic       level,
    output logic       toggle,
    output key_event_t evt
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic              sync_meta, sync_key;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] hold_cnt;
    logic              long_done;
    logic              press_q, rel_q, long_q, rpt_q, toggle_q;
    logic              accept, holding;

    // A mismatch that has lasted DB_CYCLES samples is taken as the new stable level.
    assign accept  = (sync_key != stable) && (db_cnt == DB_LAST);
    // A release being accepted this edge already counts as "not held".
    assign holding = (stable == KEY_PRESSED) && !accept;

    // NOTE: sequential state uses non-blocking assignments only; the synchroniser
    // presets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
            stable    <= 1'b1;
            db_cnt    <= '0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            toggle_q  <= TOGGLE_RST;
        end else begin
            sync_meta <= key_raw;
            sync_key  <= sync_meta;
            press_q   <= accept && (sync_key == KEY_PRESSED);
            rel_q     <= accept && (sync_key != KEY_PRESSED);
            toggle_q  <= toggle_q ^ press_q;
            if (sync_key == stable) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt <= '0;
                stable <= sync_key;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Hold counter saturates at LONG_LAST; long_done keeps KEY_long to a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else if (!holding) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= !long_done && (hold_cnt == LONG_LAST);
            if (hold_cnt == LONG_LAST) begin
                long_done <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + LONG_W'(1);
            end
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt;

    // Runs only after the long-press event; first pulse REPEAT_CYCLES after KEY_long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b0;
        end else if (!holding || !long_done) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b0;
        end else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
            rpt_q   <= 1'b0;
        end
    end
`else
    assign rpt_q = 1'b0;
`endif

    assign level  = stable;
    assign toggle = toggle_q;
    assign evt    = '{press: press_q, rel: rel_q, hold_long: long_q, rpt: rpt_q};

endmodule

// File: rtl/key_debounce_multi.sv
// N-key debouncer and event generator; auto-repeat pulses are built only when
// KEY_AUTO_REPEAT_EN is defined, otherwise KEY_repeat is tied low.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int               N_KEYS        = 4,
    parameter int               DB_CYCLES     = ms_to_cycles(DB_MS),
    parameter int               LONG_CYCLES   = ms_to_cycles(LONG_MS),
    parameter int               REPEAT_CYCLES = ms_to_cycles(REPEAT_MS),
    parameter logic [N_KEYS-1:0] TOGGLE_RST   = '1
) (
    input  logic              Clk_50MHz,
    input  logic              Reset_N,
    input  logic [N_KEYS-1:0] KEY_in,
    output logic [N_KEYS-1:0] KEY_level,
    output logic [N_KEYS-1:0] KEY_press,
    output logic [N_KEYS-1:0] KEY_release,
    output logic [N_KEYS-1:0] KEY_long,
    output logic [N_KEYS-1:0] KEY_repeat,
    output logic [N_KEYS-1:0] LED_toggle
);

    // Counters of width $clog2(1) would be zero bits wide.
    if (DB_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_debounce_multi: cycle-count parameters must be >= 2");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_event_t evt;

        key_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
`ifdef KEY_AUTO_REPEAT_EN
            .REPEAT_CYCLES (REPEAT_CYCLES),
`endif
            .TOGGLE_RST    (TOGGLE_RST[i])
        ) u_channel (
            .clk     (Clk_50MHz),
            .rst_n   (Reset_N),
            .key_raw (KEY_in[i]),
            .level   (KEY_level[i]),
            .toggle  (LED_toggle[i]),
            .evt     (evt)
        );

        assign KEY_press[i]   = evt.press;
        assign KEY_release[i] = evt.rel;
        assign KEY_long[i]    = evt.hold_long;
        assign KEY_repeat[i]  = evt.rpt;
    end

endmodule
